md_unit_e: RTL and testbench

- E-stage consumer of the latched instruction Instr_E and the forwarded operands.
- Executes mult/multu/div/divu as multi-cycle operations into the HI/LO registers.
- Services mthi/mtlo writes and mfhi/mflo reads.
- Drives Start/Busy back toward the D-stage hazard logic, which stalls further HI/LO-class instructions while an operation is in flight.

---
 rtl/md_unit_e_pkg.sv | 26 ++
 rtl/md_unit_e_if.sv | 17 +
 rtl/md_unit_e.sv | 116 +++++++++++
 tb/tb_md_unit_e.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/md_unit_e_pkg.sv
// Shared decode constants, state encoding and instruction-match helpers for the
// E-stage multiply/divide unit.
package md_unit_e_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] F_MFHI     = 6'h10;
  localparam logic [5:0] F_MTHI     = 6'h11;
  localparam logic [5:0] F_MFLO     = 6'h12;
  localparam logic [5:0] F_MTLO     = 6'h13;
  localparam logic [5:0] F_MULT     = 6'h18;
  localparam logic [5:0] F_MULTU    = 6'h19;
  localparam logic [5:0] F_DIV      = 6'h1A;
  localparam logic [5:0] F_DIVU     = 6'h1B;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} md_state_e;

  function automatic logic is_special(input logic [31:0] instr, input logic [5:0] funct);
    return (instr[31:26] == OP_SPECIAL) && (instr[5:0] == funct);
  endfunction

  function automatic logic is_md_op(input logic [31:0] instr);
    return is_special(instr, F_MULT) || is_special(instr, F_MULTU) ||
           is_special(instr, F_DIV)  || is_special(instr, F_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_e_if.sv
// E-stage operand/instruction inputs and HI/LO result bundle of the md unit.
interface md_unit_e_if;
  logic [31:0] Instr_E;
  logic [31:0] RS_E;
  logic [31:0] RT_E;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDOut;
  logic        MDRead;

  modport slave  (input  Instr_E, RS_E, RT_E,
                  output Start, Busy, HI, LO, MDOut, MDRead);
  modport master (output Instr_E, RS_E, RT_E,
                  input  Start, Busy, HI, LO, MDOut, MDRead);
endinterface

// File: rtl/md_unit_e.sv
// Multi-cycle mult/div unit: result is computed at issue and held, HI/LO commit
// after a fixed busy window; mthi/mtlo/mfhi/mflo handled in IDLE.
module md_unit_e
  import md_unit_e_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  md_unit_e_if.slave  md
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  md_state_e   state_q, state_d;
  logic [CW-1:0] count;
  logic [31:0] hi, lo, hold_hi, hold_lo;
  logic        hold_wr;

  logic [31:0] rs, rt, instr;
  logic        op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo, op_mfhi, op_mflo;
  logic        start;

  assign instr    = md.Instr_E;
  assign rs       = md.RS_E;
  assign rt       = md.RT_E;
  assign op_mult  = is_special(instr, F_MULT);
  assign op_multu = is_special(instr, F_MULTU);
  assign op_div   = is_special(instr, F_DIV);
  assign op_divu  = is_special(instr, F_DIVU);
  assign op_mthi  = is_special(instr, F_MTHI);
  assign op_mtlo  = is_special(instr, F_MTLO);
  assign op_mfhi  = is_special(instr, F_MFHI);
  assign op_mflo  = is_special(instr, F_MFLO);
  assign start    = is_md_op(instr) && (state_q == IDLE);

  // Divisor forced to 1 on zero so the divider never sees /0; commit is suppressed instead.
  logic [63:0] prod_s, prod_u;
  logic [31:0] dvs, q_s, r_s, q_u, r_u, res_hi, res_lo;
  logic        div0;

  always_comb begin
    div0   = (rt == 32'd0);
    dvs    = div0 ? 32'd1 : rt;
    prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    prod_u = {32'd0, rs} * {32'd0, rt};
    q_s    = $signed(rs) / $signed(dvs);
    r_s    = $signed(rs) % $signed(dvs);
    q_u    = rs / dvs;
    r_u    = rs % dvs;
    res_hi = prod_s[63:32];
    res_lo = prod_s[31:0];
    if (op_multu) begin
      res_hi = prod_u[63:32];
      res_lo = prod_u[31:0];
    end else if (op_div) begin
      res_hi = r_s;
      res_lo = q_s;
    end else if (op_divu) begin
      res_hi = r_u;
      res_lo = q_u;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (count == CW'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      hold_hi <= '0;
      hold_lo <= '0;
      hold_wr <= 1'b0;
    end else if (state_q == IDLE) begin
      if (start) begin
        hold_hi <= res_hi;
        hold_lo <= res_lo;
        hold_wr <= !((op_div || op_divu) && div0);
        count   <= (op_mult || op_multu) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      end else if (op_mthi) begin
        hi <= rs;
      end else if (op_mtlo) begin
        lo <= rs;
      end
    end else begin
      count <= count - 1'b1;
      if (count == CW'(1) && hold_wr) begin
        hi <= hold_hi;
        lo <= hold_lo;
      end
    end
  end

  assign md.Start  = start;
  assign md.Busy   = (state_q == RUN);
  assign md.HI     = hi;
  assign md.LO     = lo;
  assign md.MDRead = op_mfhi || op_mflo;
  assign md.MDOut  = op_mfhi ? hi : (op_mflo ? lo : 32'd0);

endmodule

// File: tb/tb_md_unit_e.sv
// Directed bench for md_unit_e: table of arithmetic vectors plus hand sequences
// for mthi/mflo, async reset mid-operation and ignored HI/LO writes while busy.
module tb_md_unit_e;
  import md_unit_e_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  md_unit_e_if md();
  md_unit_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .md(md));

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] I_MULT  = 32'h0000_0018;
  localparam logic [31:0] I_MULTU = 32'h0000_0019;
  localparam logic [31:0] I_DIV   = 32'h0000_001A;
  localparam logic [31:0] I_DIVU  = 32'h0000_001B;
  localparam logic [31:0] I_MFHI  = 32'h0000_0010;
  localparam logic [31:0] I_MTHI  = 32'h0000_0011;
  localparam logic [31:0] I_MFLO  = 32'h0000_0012;
  localparam logic [31:0] I_MTLO  = 32'h0000_0013;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (md.Busy === 1'b1 && n < 50) begin
      if (md.Start !== 1'b0) chk("start_during_busy", 32'(md.Start), 32'd0);
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    logic [31:0] lo_before;
    md.Instr_E = 32'd0;
    md.RS_E    = 32'd0;
    md.RT_E    = 32'd0;

    vecs[0] = '{I_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1] = '{I_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 5};
    vecs[2] = '{I_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{I_DIVU,  32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[4] = '{I_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 10};
    vecs[5] = '{I_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5};
    vecs[6] = '{I_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};

    #12;
    chk("rst_busy",  32'(md.Busy), 32'd0);
    chk("rst_hi",    md.HI, 32'd0);
    chk("rst_lo",    md.LO, 32'd0);
    chk("rst_start", 32'(md.Start), 32'd0);
    chk("rst_mdout", md.MDOut, 32'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      md.Instr_E = vecs[i].instr;
      md.RS_E    = vecs[i].rs;
      md.RT_E    = vecs[i].rt;
      #1;
      chk($sformatf("v%0d_start", i), 32'(md.Start), 32'd1);
      chk($sformatf("v%0d_busy0", i), 32'(md.Busy), 32'd0);
      tick();
      md.Instr_E = 32'd0;
      count_busy(n);
      chk($sformatf("v%0d_cycles", i), n, vecs[i].cyc);
      chk($sformatf("v%0d_hi", i), md.HI, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), md.LO, vecs[i].lo);
    end

    // mthi then mfhi; mtlo does not bypass into the same-cycle LO view
    md.Instr_E = I_MTHI; md.RS_E = 32'h1234_5678;
    tick();
    md.Instr_E = I_MFHI; md.RS_E = 32'd0;
    #1;
    chk("mfhi_read", 32'(md.MDRead), 32'd1);
    chk("mfhi_out",  md.MDOut, 32'h1234_5678);
    md.Instr_E = I_MFLO;
    #1;
    chk("mflo_old", md.MDOut, 32'hFFFF_FFFD);
    md.Instr_E = I_MTLO; md.RS_E = 32'hAAAA_5555;
    #1;
    chk("mtlo_no_bypass", md.LO, 32'hFFFF_FFFD);
    chk("mtlo_mdread", 32'(md.MDRead), 32'd0);
    tick();
    md.Instr_E = I_MFLO; md.RS_E = 32'd0;
    #1;
    chk("mflo_new", md.MDOut, 32'hAAAA_5555);
    tick();

    // async reset in busy cycle 4 of a divide
    md.Instr_E = I_DIV; md.RS_E = 32'd100; md.RT_E = 32'd3;
    tick();
    md.Instr_E = 32'd0;
    tick(); tick(); tick();
    chk("rst_mid_busy_pre", 32'(md.Busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(md.Busy), 32'd0);
    chk("rst_mid_hi",   md.HI, 32'd0);
    chk("rst_mid_lo",   md.LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    chk("rst_no_commit_hi", md.HI, 32'd0);
    chk("rst_no_commit_lo", md.LO, 32'd0);
    chk("rst_no_commit_busy", 32'(md.Busy), 32'd0);

    // mtlo held during busy must be ignored
    md.Instr_E = I_MULT; md.RS_E = 32'd6; md.RT_E = 32'd7;
    tick();
    md.Instr_E = I_MTLO; md.RS_E = 32'hDEAD_BEEF;
    n = 0;
    lo_before = md.LO;
    while (md.Busy === 1'b1 && n < 50) begin
      chk($sformatf("mtlo_busy_start%0d", n), 32'(md.Start), 32'd0);
      chk($sformatf("mtlo_busy_lo%0d", n), md.LO, lo_before);
      n++;
      tick();
    end
    md.Instr_E = 32'd0;
    #1;
    chk("mtlo_busy_cycles", n, 32'd5);
    chk("mtlo_busy_hi", md.HI, 32'd0);
    chk("mtlo_busy_lo", md.LO, 32'd42);
    tick();
    chk("mtlo_busy_lo_after", md.LO, 32'd42);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
